// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and types for the integer register file
package reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] regIdx_t;
    typedef logic [XLEN-1:0]       dataWord_t;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - integer register file, two combinational read ports, one clocked write port
module reg_file
    import reg_file_pkg::*;
#(
    parameter int dataWidth    = XLEN,
    parameter int AddressWidth = REG_ADDR_W
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic [AddressWidth-1:0] RegA,
    input  logic [AddressWidth-1:0] RegB,
    input  logic [AddressWidth-1:0] RegW,
    input  logic [dataWidth-1:0]    dataW,
    input  logic                    RFwrite,
    output logic [dataWidth-1:0]    dataA,
    output logic [dataWidth-1:0]    dataB
);

    localparam int NumRegs = 2 ** AddressWidth;

    logic [dataWidth-1:0] regs [NumRegs];
    logic                 writeHit;

    // x0 is excluded from the write path entirely, so an undefined enable can never reach it.
    assign writeHit = RFwrite && (RegW != '0);

    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (writeHit) begin
            regs[RegW] <= dataW;
        end
    end

    // No write-to-read bypass: same-cycle forwarding belongs to the pipeline.
    assign dataA = (RegA == '0) ? '0 : regs[RegA];
    assign dataB = (RegB == '0) ? '0 : regs[RegB];

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed vector bench for reg_file
module tb_reg_file;
    import reg_file_pkg::*;

    logic      Clk = 1'b0;
    logic      reset;
    regIdx_t   RegA, RegB, RegW;
    dataWord_t dataW, dataA, dataB;
    logic      RFwrite;

    int checks   = 0;
    int failures = 0;

    reg_file dut (
        .Clk     (Clk),
        .reset   (reset),
        .RegA    (RegA),
        .RegB    (RegB),
        .RegW    (RegW),
        .dataW   (dataW),
        .RFwrite (RFwrite),
        .dataA   (dataA),
        .dataB   (dataB)
    );

    always #5 Clk = ~Clk;

    // Expected reads are the values seen before the edge that applies this vector's write/reset.
    typedef struct {
        logic      rst;
        logic      we;
        regIdx_t   w;
        dataWord_t d;
        regIdx_t   a;
        regIdx_t   b;
        logic      chk;
        dataWord_t expA;
        dataWord_t expB;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input dataWord_t act, input dataWord_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 5'd0, 32'h0,  5'd2, 5'd0, 1'b1, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 5'd0, 32'h3,  5'd2, 5'd0, 1'b1, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 5'd0, 32'h9,  5'd2, 5'd0, 1'b1, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 5'd2, 32'h3,  5'd2, 5'd0, 1'b1, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd2, 32'h7,  5'd2, 5'd0, 1'b1, 32'h3, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 5'd6, 32'h9,  5'd2, 5'd6, 1'b1, 32'h3, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 5'd1, 32'h1,  5'd6, 5'd2, 1'b1, 32'h9, 32'h3};
        vecs[8]  = '{1'b0, 1'b1, 5'd7, 32'hB,  5'd1, 5'd6, 1'b1, 32'h1, 32'h9};
        vecs[9]  = '{1'b0, 1'b1, 5'd7, 32'hB,  5'd7, 5'd1, 1'b1, 32'hB, 32'h1};
        vecs[10] = '{1'b0, 1'b0, 5'd7, 32'hFF, 5'd7, 5'd0, 1'b1, 32'hB, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 5'd7, 32'h55, 5'd7, 5'd7, 1'b1, 32'hB, 32'hB};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0,  5'd7, 5'd6, 1'b1, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0,  5'd1, 5'd2, 1'b1, 32'h0, 32'h0};

        reset = 1'b1; RFwrite = 1'b0; RegA = '0; RegB = '0; RegW = '0; dataW = '0;

        for (int i = 0; i < 14; i++) begin
            @(negedge Clk);
            reset   = vecs[i].rst;
            RFwrite = vecs[i].we;
            RegW    = vecs[i].w;
            dataW   = vecs[i].d;
            RegA    = vecs[i].a;
            RegB    = vecs[i].b;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d portA", i), dataA, vecs[i].expA);
                check($sformatf("vec%0d portB", i), dataB, vecs[i].expB);
            end
        end

        // Same index written and read in one cycle: old value before the edge, new after.
        @(negedge Clk);
        reset = 1'b0; RFwrite = 1'b1; RegW = 5'd31; dataW = 32'hDEADBEEF;
        RegA = 5'd31; RegB = 5'd31;
        #1;
        check("raw pre-edge A", dataA, 32'h0);
        check("raw pre-edge B", dataB, 32'h0);
        @(posedge Clk);
        #1;
        check("raw post-edge A", dataA, 32'hDEADBEEF);
        check("raw post-edge B", dataB, 32'hDEADBEEF);

        // Index change alone must show up with no clock edge.
        @(negedge Clk);
        RFwrite = 1'b0; RegW = 5'd0; dataW = '0;
        RegA = 5'd0;
        #1;
        check("comb index to x0", dataA, 32'h0);
        RegA = 5'd31;
        #1;
        check("comb index to x31", dataA, 32'hDEADBEEF);

        // Undefined enable aimed at x0 must leave it at zero.
        @(negedge Clk);
        RFwrite = 1'bx; RegW = 5'd0; dataW = 32'hFFFFFFFF; RegB = 5'd0;
        @(posedge Clk);
        #1;
        check("x0 with unknown enable", dataB, 32'h0);
        check("x31 untouched by x0 write", dataA, 32'hDEADBEEF);

        @(negedge Clk);
        RFwrite = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
